regfile_datapath_de2: RTL and testbench

Board-level, single-clock datapath top that generalises the switch-driven DE2 datapath to a parametrised register file with a selectable ALU, status flags, a step counter and an auto-run mode. A push-button is synchronised and debounced internally and converted into a one-cycle step enable, so all state is clocked by `CLOCK_50` rather than by a debounced signal. Display encoding (hex digits, LEDs) is done outside this block, which exposes raw register values and flags.

---
 rtl/regfile_datapath_de2.sv | 171 +++++++++++++++++
 tb/tb_regfile_datapath_de2.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_datapath_de2.sv
// regfile_datapath_de2: board-level single-clock datapath.
// A raw push-button is synchronised and debounced into a one-cycle step enable
// (or an internal divider generates steps in run mode). Each step executes one
// ALU operation on a small register file and updates zero/carry flags and a
// step counter.
//
// Ports:
//   CLOCK_50   - system clock, all state on rising edge
//   RST_N      - asynchronous active-low reset
//   key_step_n - raw active-low step button (asynchronous)
//   run        - 1: auto-run every RUN_PERIOD cycles, 0: step on button press
//   imm        - immediate operand
//   op_sel     - 00 load imm, 01 add, 10 sub, 11 xor
//   dst_sel    - destination / first-operand register index
//   src_sel    - second-operand register index
//   wr_en      - write result to R[dst_sel] on step
//   dst_val    - R[dst_sel], combinational
//   src_val    - R[src_sel], combinational
//   zero       - last executed result was zero
//   carry      - carry (add) / borrow (sub) of last executed step
//   step_cnt   - number of executed steps, wraps
//   step_pulse - high in the cycle a step executes
module regfile_datapath_de2 #(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned NREG            = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned RUN_PERIOD      = 25000000,
  localparam int unsigned SELW           = $clog2(NREG)
) (
  input  logic             CLOCK_50,
  input  logic             RST_N,
  input  logic             key_step_n,
  input  logic             run,
  input  logic [WIDTH-1:0] imm,
  input  logic [1:0]       op_sel,
  input  logic [SELW-1:0]  dst_sel,
  input  logic [SELW-1:0]  src_sel,
  input  logic             wr_en,
  output logic [WIDTH-1:0] dst_val,
  output logic [WIDTH-1:0] src_val,
  output logic             zero,
  output logic             carry,
  output logic [7:0]       step_cnt,
  output logic             step_pulse
);

  localparam int unsigned DbW  = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned RunW = $clog2(RUN_PERIOD);

  // Synchroniser flops reset to 1 (button released).
  logic            sync1_q, sync2_q;
  logic            pressed_q, pressed_d;
  logic [DbW-1:0]  db_cnt_q, db_cnt_d;
  logic [RunW-1:0] run_cnt_q, run_cnt_d;
  logic            step_pulse_q, step_pulse_d;
  logic            zero_q, zero_d;
  logic            carry_q, carry_d;
  logic [7:0]      step_cnt_q, step_cnt_d;
  logic [WIDTH-1:0] regs_q [NREG];
  logic [WIDTH-1:0] regs_d [NREG];

  logic             btn_lvl;
  logic             press_rise;
  logic             run_tick;
  logic [WIDTH-1:0] op_a, op_b, result;
  logic [WIDTH:0]   sum_w, diff_w;
  logic             res_carry;

  // Debounce: accept a new level only after DEBOUNCE_CYCLES consecutive
  // differing samples; any agreeing sample restarts the count.
  always_comb begin
    btn_lvl    = ~sync2_q;
    pressed_d  = pressed_q;
    db_cnt_d   = '0;
    press_rise = 1'b0;
    if (btn_lvl != pressed_q) begin
      if (db_cnt_q == DbW'(DEBOUNCE_CYCLES - 1)) begin
        pressed_d  = btn_lvl;
        press_rise = btn_lvl;
      end else begin
        db_cnt_d = db_cnt_q + DbW'(1);
      end
    end
  end

  // Run-mode divider, held at 0 outside run mode so a new run starts a full period.
  always_comb begin
    run_cnt_d = '0;
    run_tick  = 1'b0;
    if (run) begin
      if (run_cnt_q == RunW'(RUN_PERIOD - 1)) begin
        run_tick = 1'b1;
      end else begin
        run_cnt_d = run_cnt_q + RunW'(1);
      end
    end
    step_pulse_d = run ? run_tick : press_rise;
  end

  // ALU; the extra top bit of sum/diff is the carry/borrow.
  always_comb begin
    op_a      = regs_q[dst_sel];
    op_b      = regs_q[src_sel];
    sum_w     = {1'b0, op_a} + {1'b0, op_b};
    diff_w    = {1'b0, op_a} - {1'b0, op_b};
    result    = '0;
    res_carry = 1'b0;
    unique case (op_sel)
      2'b00: result = imm;
      2'b01: begin
        result    = sum_w[WIDTH-1:0];
        res_carry = sum_w[WIDTH];
      end
      2'b10: begin
        result    = diff_w[WIDTH-1:0];
        res_carry = diff_w[WIDTH];
      end
      default: result = op_a ^ op_b;
    endcase
  end

  // Execute in the step_pulse cycle; results visible the following cycle.
  always_comb begin
    regs_d     = regs_q;
    zero_d     = zero_q;
    carry_d    = carry_q;
    step_cnt_d = step_cnt_q;
    if (step_pulse_q) begin
      if (wr_en) begin
        regs_d[dst_sel] = result;
      end
      zero_d     = (result == '0);
      carry_d    = res_carry;
      step_cnt_d = step_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      pressed_q    <= 1'b0;
      db_cnt_q     <= '0;
      run_cnt_q    <= '0;
      step_pulse_q <= 1'b0;
      zero_q       <= 1'b0;
      carry_q      <= 1'b0;
      step_cnt_q   <= '0;
      regs_q       <= '{default: '0};
    end else begin
      sync1_q      <= key_step_n;
      sync2_q      <= sync1_q;
      pressed_q    <= pressed_d;
      db_cnt_q     <= db_cnt_d;
      run_cnt_q    <= run_cnt_d;
      step_pulse_q <= step_pulse_d;
      zero_q       <= zero_d;
      carry_q      <= carry_d;
      step_cnt_q   <= step_cnt_d;
      regs_q       <= regs_d;
    end
  end

  assign dst_val    = regs_q[dst_sel];
  assign src_val    = regs_q[src_sel];
  assign zero       = zero_q;
  assign carry      = carry_q;
  assign step_cnt   = step_cnt_q;
  assign step_pulse = step_pulse_q;

endmodule

// File: tb/tb_regfile_datapath_de2.sv
module tb_regfile_datapath_de2;

  localparam int unsigned Width    = 8;
  localparam int unsigned Nreg     = 4;
  localparam int unsigned Debounce = 4;
  localparam int unsigned Period   = 8;

  logic       clk;
  logic       rst_n;
  logic       key_step_n;
  logic       run;
  logic [7:0] imm;
  logic [1:0] op_sel;
  logic [1:0] dst_sel;
  logic [1:0] src_sel;
  logic       wr_en;
  logic [7:0] dst_val;
  logic [7:0] src_val;
  logic       zero;
  logic       carry;
  logic [7:0] step_cnt;
  logic       step_pulse;

  int n_checks = 0;
  int n_errors = 0;
  int pulse_cnt = 0;
  time pulse_times[$];

  regfile_datapath_de2 #(
    .WIDTH          (Width),
    .NREG           (Nreg),
    .DEBOUNCE_CYCLES(Debounce),
    .RUN_PERIOD     (Period)
  ) dut (
    .CLOCK_50  (clk),
    .RST_N     (rst_n),
    .key_step_n(key_step_n),
    .run       (run),
    .imm       (imm),
    .op_sel    (op_sel),
    .dst_sel   (dst_sel),
    .src_sel   (src_sel),
    .wr_en     (wr_en),
    .dst_val   (dst_val),
    .src_val   (src_val),
    .zero      (zero),
    .carry     (carry),
    .step_cnt  (step_cnt),
    .step_pulse(step_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count step pulses away from the active edge.
  always @(negedge clk) begin
    if (step_pulse) begin
      pulse_cnt++;
      pulse_times.push_back($time);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Clean press and release, each held well past the debounce window.
  task automatic press();
    key_step_n = 1'b0;
    tick(Debounce + 8);
    key_step_n = 1'b1;
    tick(Debounce + 8);
  endtask

  task automatic do_op(input logic [1:0] op, input logic [1:0] dst, input logic [1:0] src,
                       input logic [7:0] im, input logic we);
    op_sel  = op;
    dst_sel = dst;
    src_sel = src;
    imm     = im;
    wr_en   = we;
    press();
  endtask

  initial begin
    int base;
    int n;
    bit done;

    rst_n      = 1'b0;
    key_step_n = 1'b1;
    run        = 1'b0;
    imm        = '0;
    op_sel     = '0;
    dst_sel    = '0;
    src_sel    = '0;
    wr_en      = 1'b0;
    tick(3);

    check("rst_dst_val", dst_val, 0);
    check("rst_src_val", src_val, 0);
    check("rst_zero", zero, 0);
    check("rst_carry", carry, 0);
    check("rst_step_cnt", step_cnt, 0);
    check("rst_step_pulse", step_pulse, 0);
    rst_n = 1'b1;
    tick(2);

    // Load R1 = 0x5A
    base = pulse_cnt;
    do_op(2'b00, 2'd1, 2'd0, 8'h5A, 1'b1);
    check("load_pulses", pulse_cnt - base, 1);
    check("load_r1", dst_val, 8'h5A);
    check("load_cnt", step_cnt, 1);
    check("load_zero", zero, 0);

    // R0 = 0xF0, R1 = 0x20, then ALU ops
    do_op(2'b00, 2'd0, 2'd0, 8'hF0, 1'b1);
    do_op(2'b00, 2'd1, 2'd0, 8'h20, 1'b1);
    do_op(2'b01, 2'd0, 2'd1, 8'h00, 1'b1);
    check("add_r0", dst_val, 8'h10);
    check("add_carry", carry, 1);
    check("add_zero", zero, 0);
    do_op(2'b10, 2'd1, 2'd0, 8'h00, 1'b1);
    check("sub_r1", dst_val, 8'h10);
    check("sub_carry", carry, 0);
    do_op(2'b10, 2'd0, 2'd1, 8'h00, 1'b1);
    check("sub_eq_r0", dst_val, 8'h00);
    check("sub_eq_zero", zero, 1);
    check("sub_eq_carry", carry, 0);

    // Compare without write: R0(0) - R1(0x10) borrows
    do_op(2'b10, 2'd0, 2'd1, 8'h00, 1'b0);
    check("cmp_r0_kept", dst_val, 8'h00);
    check("cmp_r1_kept", src_val, 8'h10);
    check("cmp_carry", carry, 1);
    check("cmp_zero", zero, 0);
    check("cmp_cnt", step_cnt, 7);

    // dst == src: xor with itself clears R1
    do_op(2'b11, 2'd1, 2'd1, 8'h00, 1'b1);
    check("self_xor_r1", dst_val, 8'h00);
    check("self_xor_zero", zero, 1);

    // Bouncing press: three 3-cycle low glitches, then held low, then release
    op_sel  = 2'b00;
    dst_sel = 2'd2;
    imm     = 8'h33;
    wr_en   = 1'b1;
    base    = pulse_cnt;
    for (int i = 0; i < 3; i++) begin
      key_step_n = 1'b0;
      tick(3);
      key_step_n = 1'b1;
      tick(2);
    end
    tick(4);
    check("bounce_no_step", pulse_cnt - base, 0);
    key_step_n = 1'b0;
    tick(20);
    key_step_n = 1'b1;
    tick(20);
    check("bounce_pulses", pulse_cnt - base, 1);
    check("bounce_r2", dst_val, 8'h33);
    check("bounce_cnt", step_cnt, 9);

    // Run mode for 40 cycles, button pressed meanwhile
    op_sel = 2'b00;
    imm    = 8'h00;
    wr_en  = 1'b0;
    base   = pulse_cnt;
    pulse_times.delete();
    run = 1'b1;
    tick(10);
    key_step_n = 1'b0;
    tick(10);
    key_step_n = 1'b1;
    tick(20);
    run = 1'b0;
    tick(12);
    check("run_pulses", pulse_cnt - base, 5);
    if (pulse_times.size() >= 2) begin
      for (int i = 1; i < pulse_times.size(); i++) begin
        check("run_spacing", 32'(pulse_times[i] - pulse_times[i-1]), 80);
      end
    end
    check("run_cnt", step_cnt, 14);
    check("run_r2_kept", dst_val, 8'h33);

    // Wrap step_cnt with 242 more auto steps
    run  = 1'b1;
    n    = 0;
    done = 1'b0;
    for (int c = 0; c < 3000 && !done; c++) begin
      tick(1);
      if (step_pulse) begin
        n++;
        if (n == 242) begin
          run  = 1'b0;
          done = 1'b1;
        end
      end
    end
    run = 1'b0;
    check("wrap_reached", done, 1);
    tick(3);
    check("wrap_cnt", step_cnt, 0);

    // Reset mid-debounce
    base       = pulse_cnt;
    key_step_n = 1'b0;
    tick(4);
    #2 rst_n = 1'b0;
    #1;
    check("rstdb_pulse", step_pulse, 0);
    check("rstdb_r2", dst_val, 0);
    check("rstdb_cnt", step_cnt, 0);
    tick(2);
    key_step_n = 1'b1;
    rst_n      = 1'b1;
    tick(20);
    check("rstdb_no_step", pulse_cnt - base, 0);

    // Reset mid-run-period
    run = 1'b1;
    tick(5);
    rst_n = 1'b0;
    run   = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(20);
    check("rstrun_no_step", pulse_cnt - base, 0);
    check("rstrun_zero", zero, 0);
    check("rstrun_carry", carry, 0);

    // Normal press after reset
    do_op(2'b00, 2'd0, 2'd2, 8'h77, 1'b1);
    check("post_rst_pulses", pulse_cnt - base, 1);
    check("post_rst_r0", dst_val, 8'h77);
    check("post_rst_r2", src_val, 8'h00);
    check("post_rst_cnt", step_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
